// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and receiver state encoding.
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_VISIBLE + H_FP;
  localparam int V_SYNC_START = V_VISIBLE + V_FP;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    HTRACK = 2'd1,
    VTRACK = 2'd2,
    LOCKED = 2'd3
  } rx_state_e;

  // 10-bit increment that sticks at all-ones
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one sync input, normalises it to active-high and flags the
// cycle where the registered sync first becomes active.
module sync_edge_detect #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sync_i,
  output logic fall_o
);

  logic act_q, act_prev_q;

  // Capture normalised sync and keep one cycle of history for the edge
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      act_q      <= 1'b0;
      act_prev_q <= 1'b0;
    end else begin
      act_q      <= ACTIVE_LOW ? ~sync_i : sync_i;
      act_prev_q <= act_q;
    end
  end

  assign fall_o = act_q & ~act_prev_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers sx/sy/de from raw hsync/vsync, tracks lock
// and counts lock losses. Output position trails the transmitter by 2 clocks.
module vga_sync_receiver
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE       = vga_timing_pkg::H_VISIBLE,
  parameter int H_FP            = vga_timing_pkg::H_FP,
  parameter int H_SYNC          = vga_timing_pkg::H_SYNC,
  parameter int H_BP            = vga_timing_pkg::H_BP,
  parameter int V_VISIBLE       = vga_timing_pkg::V_VISIBLE,
  parameter int V_FP            = vga_timing_pkg::V_FP,
  parameter int V_SYNC          = vga_timing_pkg::V_SYNC,
  parameter int V_BP            = vga_timing_pkg::V_BP,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_LINES      = 4,
  parameter int H_TIMEOUT       = 816
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] sx,
  output logic [9:0] sy,
  output logic       de,
  output logic       locked,
  output logic       frame_start,
  output logic [7:0] err_count
);

  localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
  localparam logic [9:0] H_LOAD  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] V_LOAD  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] H_TOT10 = 10'(H_TOT);
  localparam logic [9:0] V_TOT10 = 10'(V_TOT);
  localparam logic [9:0] H_TO10  = 10'(H_TIMEOUT);
  localparam logic [9:0] H_VIS10 = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS10 = 10'(V_VISIBLE);

  logic hfall, vfall;

  sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_hs (
    .clk_i(clk), .rst_ni(rst_n), .sync_i(hsync), .fall_o(hfall)
  );

  sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_vs (
    .clk_i(clk), .rst_ni(rst_n), .sync_i(vsync), .fall_o(vfall)
  );

  rx_state_e  state_q;
  logic [9:0] sx_q, sx_d, sy_q, sy_d;
  logic [9:0] per_q, per_d, lines_q, lines_cnt, lines_d;
  logic [7:0] good_q, err_q;
  logic       armed_q, locked_q, de_q, fs_q;
  logic       line_good, bad_line, frame_good, timeout, lose, lock_d;

  // Next position, period/line measurements and lock decision
  always_comb begin
    sx_d = (sx_q == H_LAST) ? 10'd0 : sx_q + 10'd1;
    sy_d = sy_q;
    if (hfall) begin
      // Reload lands sx on the sync start two clocks after the tx edge
      sx_d = H_LOAD;
    end else if (sx_q == H_LAST) begin
      sy_d = (sy_q == V_LAST) ? 10'd0 : sy_q + 10'd1;
    end
    if (vfall) sy_d = V_LOAD;

    line_good = (per_q == H_TOT10);
    bad_line  = hfall & ~line_good;
    per_d     = hfall ? 10'd1 : sat_inc10(per_q);

    // The h-fall of this cycle belongs to the frame the v-fall closes
    lines_cnt  = hfall ? sat_inc10(lines_q) : lines_q;
    frame_good = (lines_cnt == V_TOT10);
    lines_d    = vfall ? 10'd0 : lines_cnt;

    timeout = (per_q >= H_TO10);
    lose    = (state_q == LOCKED) & (bad_line | (vfall & ~frame_good) | timeout);
    lock_d  = ((state_q == VTRACK) & ~bad_line & vfall & armed_q & frame_good) |
              ((state_q == LOCKED) & ~lose);
  end

  // Lock FSM with registered lock flag and saturating loss counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= SEARCH;
      good_q   <= 8'd0;
      armed_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 8'd0;
    end else begin
      locked_q <= lock_d;
      case (state_q)
        SEARCH: if (hfall) begin
          state_q <= HTRACK;
          good_q  <= 8'd0;
        end
        HTRACK: if (hfall) begin
          if (!line_good) begin
            good_q <= 8'd0;
          end else if ((int'(good_q) + 1) >= LOCK_LINES) begin
            state_q <= VTRACK;
            good_q  <= 8'd0;
            armed_q <= 1'b0;
          end else begin
            good_q <= good_q + 8'd1;
          end
        end
        VTRACK: begin
          if (bad_line) begin
            state_q <= HTRACK;
            good_q  <= 8'd0;
          end else if (vfall) begin
            // First v-fall only starts a measurement; a bad frame re-arms
            if (armed_q && frame_good) state_q <= LOCKED;
            armed_q <= 1'b1;
          end
        end
        LOCKED: if (lose) begin
          state_q <= SEARCH;
          if (err_q != 8'hFF) err_q <= err_q + 8'd1;
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  // Position counters and registered de/frame_start aligned with sx/sy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sx_q    <= 10'd0;
      sy_q    <= 10'd0;
      per_q   <= 10'd0;
      lines_q <= 10'd0;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      per_q   <= per_d;
      lines_q <= lines_d;
      de_q    <= lock_d & (sx_d < H_VIS10) & (sy_d < V_VIS10);
      fs_q    <= lock_d & (sx_d == 10'd0) & (sy_d == 10'd0);
    end
  end

  assign sx          = sx_q;
  assign sy          = sy_q;
  assign de          = de_q;
  assign locked      = locked_q;
  assign frame_start = fs_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a shrunken 10x6 raster so that
// locking, loss and saturation scenarios fit in a short run.
module tb_vga_sync_receiver;
  import vga_timing_pkg::*;

  localparam int TB_HV = 6, TB_HFP = 1, TB_HS = 2, TB_HBP = 1;
  localparam int TB_VV = 3, TB_VFP = 1, TB_VS = 1, TB_VBP = 1;
  localparam int TB_HT = TB_HV + TB_HFP + TB_HS + TB_HBP;   // 10
  localparam int TB_VT = TB_VV + TB_VFP + TB_VS + TB_VBP;   // 6
  localparam int TB_HSS = TB_HV + TB_HFP;                   // 7
  localparam int TB_VSS = TB_VV + TB_VFP;                   // 4
  localparam int TB_TO = 14;
  localparam int TB_FRAME = TB_HT * TB_VT;                  // 60

  logic       clk = 1'b0, rst_n = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic [9:0] sx, sy;
  logic       de, locked, frame_start;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  vga_sync_receiver #(
    .H_VISIBLE(TB_HV), .H_FP(TB_HFP), .H_SYNC(TB_HS), .H_BP(TB_HBP),
    .V_VISIBLE(TB_VV), .V_FP(TB_VFP), .V_SYNC(TB_VS), .V_BP(TB_VBP),
    .SYNC_ACTIVE_LOW(1), .LOCK_LINES(4), .H_TIMEOUT(TB_TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
    .sx(sx), .sy(sy), .de(de), .locked(locked),
    .frame_start(frame_start), .err_count(err_count)
  );

  int n_tests = 0, n_fail = 0;
  int cyc = 0, vcyc = 0, tx_frame = 0;
  int tx_sx = 0, tx_sy = 0, d1_sx = 0, d1_sy = 0, d2_sx = 0, d2_sy = 0;
  bit run = 1'b0, hs_kill = 1'b0, short_req = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // Advance the transmitter one pixel just after the edge, then park on negedge
  task automatic tick();
    @(posedge clk); #1;
    d2_sx = d1_sx; d2_sy = d1_sy;
    d1_sx = tx_sx; d1_sy = tx_sy;
    if (run) begin
      if (tx_sx == TB_HT - 1 || (short_req && tx_sx == TB_HT - 2)) begin
        if (tx_sx == TB_HT - 2) short_req = 1'b0;
        tx_sx = 0;
        if (tx_sy == TB_VT - 1) begin
          tx_sy = 0;
          tx_frame++;
        end else begin
          tx_sy++;
        end
      end else begin
        tx_sx++;
      end
    end
    hsync = !(tx_sx >= TB_HSS && tx_sx < TB_HSS + TB_HS && !hs_kill);
    vsync = !(tx_sy >= TB_VSS && tx_sy < TB_VSS + TB_VS);
    cyc++;
    if (tx_sx == 0 && tx_sy == TB_VSS) vcyc = cyc;
    @(negedge clk);
  endtask

  task automatic run_to(input int x, input int y);
    for (int i = 0; i < 2000 && !(tx_sx == x && tx_sy == y); i++) tick();
  endtask

  task automatic wait_locked(input logic val, input int bound, input string tag);
    for (int i = 0; i < bound && locked !== val; i++) tick();
    chk(tag, locked, val);
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_sx"}, sx, 0);
    chk({pfx, "_sy"}, sy, 0);
    chk({pfx, "_de"}, de, 0);
    chk({pfx, "_locked"}, locked, 0);
    chk({pfx, "_fs"}, frame_start, 0);
    chk({pfx, "_err"}, err_count, 0);
    chk({pfx, "_state"}, 32'(dut.state_q), 32'(SEARCH));
  endtask

  initial begin
    int mism, fs;
    logic exp_de, exp_fs;

    // Reset hold with inactive syncs
    rst_n = 1'b0;
    repeat (5) tick();
    chk_reset("rst");
    rst_n = 1'b1;
    mism = 0;
    repeat (2000) begin
      tick();
      if (locked || de || frame_start) mism++;
    end
    chk("idle_nolock", mism, 0);
    chk("idle_err", err_count, 0);

    // Acquire: HTRACK completes on line 4 after the frame-0 v-fall, so frame 1
    // arms and the frame-2 v-fall locks, two clocks after tx reaches (0,4)
    run = 1'b1;
    for (int i = 0; i < 600 && !locked; i++) tick();
    chk("lock_up", locked, 1);
    chk("lock_frame", tx_frame, 2);
    chk("lock_lat", cyc - vcyc, 2);
    chk("lock_sx", sx, 0);
    chk("lock_sy", sy, TB_VSS);
    chk("lock_err", err_count, 0);

    // Two locked frames: outputs equal the transmitter delayed 2 clocks
    mism = 0; fs = 0;
    repeat (2 * TB_FRAME) begin
      tick();
      exp_de = (d2_sx < TB_HV) && (d2_sy < TB_VV);
      exp_fs = (d2_sx == 0) && (d2_sy == 0);
      if (sx != 10'(d2_sx) || sy != 10'(d2_sy) || de !== exp_de ||
          locked !== 1'b1 || frame_start !== exp_fs) mism++;
      if (frame_start) fs++;
    end
    chk("track_mism", mism, 0);
    chk("track_fs", fs, 2);

    // Short line 1: next h-fall at tx (7,2) has period 9, lock drops 2 clocks later
    run_to(0, 1);
    short_req = 1'b1;
    run_to(TB_HSS, 2);
    tick();
    chk("short_hold", locked, 1);
    tick();
    chk("short_drop", locked, 0);
    chk("short_err", err_count, 1);
    chk("short_de", de, 0);
    wait_locked(1'b1, 400, "relock1");
    chk("relock1_err", err_count, 1);

    // Kill hsync after the line-0 pulse: period hits 14 and lock drops when
    // tx shows (3,2); one clock earlier rx is at visible pixel (0,2)
    run_to(0, 1);
    hs_kill = 1'b1;
    run_to(2, 2);
    chk("to_hold", locked, 1);
    chk("to_de_on", de, 1);
    tick();
    chk("to_drop", locked, 0);
    chk("to_de", de, 0);
    chk("to_err", err_count, 2);
    run_to(0, 4);
    hs_kill = 1'b0;
    wait_locked(1'b1, 400, "relock2");

    // Many lock losses saturate the error counter
    for (int k = 0; k < 300; k++) begin
      short_req = 1'b1;
      wait_locked(1'b0, 60, "sat_drop");
      wait_locked(1'b1, 400, "sat_relock");
    end
    chk("err_sat", err_count, 255);

    // One-cycle reset mid-frame while locked
    run_to(3, 1);
    chk("pre_rst_locked", locked, 1);
    rst_n = 1'b0;
    tick();
    chk_reset("mid_rst");
    rst_n = 1'b1;
    tick();
    chk("post_rst_locked", locked, 0);
    chk("post_rst_err", err_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
